// File: rtl/router_pkg.sv
// Constants and types shared by the router blocks (router_syn, FSM, output FIFOs).
// Header byte layout: payload length in bits 7:2, destination port in bits 1:0.
package router_pkg;
  localparam int WIDTH       = 8;
  localparam int DEPTH       = 16;
  localparam int AW          = 4;
  localparam int CW          = 7;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int DEST_MSB    = 1;
  localparam int DEST_LSB    = 0;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [WIDTH:0]   word_t;
  typedef logic [AW:0]      ptr_t;
  typedef logic [CW-1:0]    cnt_t;

  // Words still to be read after a header: payload plus one parity byte.
  function automatic cnt_t pkt_words(data_t hdr);
    return cnt_t'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + cnt_t'(1);
  endfunction

  function automatic logic [1:0] dest_addr(data_t hdr);
    return hdr[DEST_MSB:DEST_LSB];
  endfunction
endpackage

// File: rtl/router_fifo_if.sv
// Write/read bus between router_syn, one output FIFO and that port's consumer.
interface router_fifo_if;
  import router_pkg::*;

  logic  soft_reset;
  logic  write_enb;
  logic  read_enb;
  logic  lfd_state;
  data_t data_in;
  data_t data_out;
  logic  full;
  logic  empty;
  logic  pkt_busy;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_busy
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_busy
  );
endinterface

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router: DEPTH-entry FIFO whose words carry a
// header tag, so the read side can count packet length and flag mid-packet state.
module router_fifo
  import router_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  router_fifo_if.slave  bus
);

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  logic  rst_meta_q;
  logic  rst_sync_q;

  word_t mem_q [DEPTH];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  data_t data_out_q, data_out_d;

  logic  full, empty;
  logic  wr_fire, rd_fire;
  word_t rd_word;

  // Reset asserts immediately but releases two clocks later, in step with clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_fire = bus.write_enb && !full;
  assign rd_fire = bus.read_enb && !empty;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (bus.soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      data_out_d = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = rd_word[WIDTH-1:0];
        // A header always reloads, even if the previous packet was cut short.
        if (rd_word[WIDTH]) begin
          count_d = pkt_words(rd_word[WIDTH-1:0]);
        end else if (count_q != '0) begin
          count_d = count_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is never cleared; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire && !bus.soft_reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.pkt_busy = (count_q != '0);

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: packet tagging, full/empty limits, collisions,
// soft flush, pointer wrap and asynchronous reset.
module tb_router_fifo;
  import router_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  router_fifo_if bus();

  router_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d, input logic lfd);
    bus.write_enb = 1'b1;
    bus.data_in   = d;
    bus.lfd_state = lfd;
    tick();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic do_read();
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.empty, bus.full, bus.pkt_busy} !== 3'b100)
      $display("[TB] FAIL reset_flags got e/f/b=%b%b%b exp 100", bus.empty, bus.full, bus.pkt_busy);
    else passed++;
    checks++;
    if (bus.data_out !== 8'h00) $display("[TB] FAIL reset_data got %h exp 00", bus.data_out);
    else passed++;
    tick();
    release_reset();
    bus.read_enb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'h00) $display("[TB] FAIL empty_read%0d got %h exp 00", i, bus.data_out);
      else passed++;
    end
    bus.read_enb = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) $display("[TB] FAIL empty_after_reads got %b exp 1", bus.empty);
    else passed++;
  endtask

  task automatic test_packet();
    logic [7:0] exp_data [5];
    logic       exp_busy [5];
    exp_data = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_write(8'h0C, 1'b1);
    for (int i = 1; i < 5; i++) do_write(exp_data[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_read();
      checks++;
      if (bus.data_out !== exp_data[i])
        $display("[TB] FAIL pkt_data%0d got %h exp %h", i, bus.data_out, exp_data[i]);
      else passed++;
      checks++;
      if (bus.pkt_busy !== exp_busy[i])
        $display("[TB] FAIL pkt_busy%0d got %b exp %b", i, bus.pkt_busy, exp_busy[i]);
      else passed++;
    end
    checks++;
    if (bus.empty !== 1'b1) $display("[TB] FAIL pkt_empty got %b exp 1", bus.empty);
    else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.full !== 1'b0) $display("[TB] FAIL full_early%0d got %b exp 0", i, bus.full);
      else passed++;
      do_write(8'h80 + 8'(i), 1'b0);
    end
    checks++;
    if (bus.full !== 1'b1) $display("[TB] FAIL full_set got %b exp 1", bus.full);
    else passed++;
    do_write(8'hAA, 1'b0);
    checks++;
    if (bus.full !== 1'b1) $display("[TB] FAIL full_after_drop got %b exp 1", bus.full);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      do_read();
      checks++;
      if (bus.data_out !== 8'h80 + 8'(i))
        $display("[TB] FAIL full_read%0d got %h exp %h", i, bus.data_out, 8'h80 + 8'(i));
      else passed++;
    end
    checks++;
    if (bus.empty !== 1'b1) $display("[TB] FAIL full_drained got %b exp 1", bus.empty);
    else passed++;
  endtask

  task automatic test_collision();
    for (int i = 0; i < 16; i++) do_write(8'h60 + 8'(i), 1'b0);
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'h55;
    tick();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    checks++;
    if (bus.data_out !== 8'h60) $display("[TB] FAIL coll_full_data got %h exp 60", bus.data_out);
    else passed++;
    checks++;
    if (bus.full !== 1'b0) $display("[TB] FAIL coll_full_flag got %b exp 0", bus.full);
    else passed++;
    repeat (15) do_read();
    checks++;
    if (bus.data_out !== 8'h6F) $display("[TB] FAIL coll_last got %h exp 6F", bus.data_out);
    else passed++;
    checks++;
    if (bus.empty !== 1'b1) $display("[TB] FAIL coll_drop_empty got %b exp 1", bus.empty);
    else passed++;
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'h77;
    tick();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    checks++;
    if (bus.empty !== 1'b0) $display("[TB] FAIL coll_empty_flag got %b exp 0", bus.empty);
    else passed++;
    checks++;
    if (bus.data_out !== 8'h6F) $display("[TB] FAIL coll_empty_hold got %h exp 6F", bus.data_out);
    else passed++;
    do_read();
    checks++;
    if (bus.data_out !== 8'h77) $display("[TB] FAIL coll_empty_write got %h exp 77", bus.data_out);
    else passed++;
  endtask

  task automatic test_soft_reset();
    do_write(8'h14, 1'b1);
    for (int i = 1; i < 8; i++) do_write(8'h10 + 8'(i), 1'b0);
    repeat (3) do_read();
    checks++;
    if ({bus.data_out, bus.pkt_busy} !== {8'h12, 1'b1})
      $display("[TB] FAIL sr_before got %h/%b exp 12/1", bus.data_out, bus.pkt_busy);
    else passed++;
    bus.soft_reset = 1'b1;
    bus.write_enb  = 1'b1;
    bus.data_in    = 8'h99;
    tick();
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    checks++;
    if ({bus.empty, bus.pkt_busy} !== 2'b10)
      $display("[TB] FAIL sr_flags got e/b=%b%b exp 10", bus.empty, bus.pkt_busy);
    else passed++;
    checks++;
    if (bus.data_out !== 8'h00) $display("[TB] FAIL sr_data got %h exp 00", bus.data_out);
    else passed++;
    do_read();
    checks++;
    if ({bus.data_out, bus.empty} !== {8'h00, 1'b1})
      $display("[TB] FAIL sr_write_lost got %h/%b exp 00/1", bus.data_out, bus.empty);
    else passed++;
  endtask

  task automatic test_wrap_and_async_reset();
    logic [7:0] v;
    for (int i = 0; i < 16; i++) do_write(8'hC0 + 8'(i), 1'b0);
    checks++;
    if (bus.full !== 1'b1) $display("[TB] FAIL wrap_full1 got %b exp 1", bus.full);
    else passed++;
    for (int i = 0; i < 16; i++) do_read();
    checks++;
    if ({bus.data_out, bus.empty} !== {8'hCF, 1'b1})
      $display("[TB] FAIL wrap_empty1 got %h/%b exp CF/1", bus.data_out, bus.empty);
    else passed++;
    for (int i = 0; i < 24; i++) begin
      v = 8'(i * 7 + 3);
      do_write(v, 1'b0);
      do_read();
      checks++;
      if ({bus.data_out, bus.empty, bus.full} !== {v, 2'b10})
        $display("[TB] FAIL wrap_pair%0d got %h/%b%b exp %h/10", i, bus.data_out, bus.empty, bus.full, v);
      else passed++;
    end
    do_write(8'h20, 1'b1);
    for (int i = 1; i < 16; i++) do_write(8'hD0 + 8'(i), 1'b0);
    checks++;
    if (bus.full !== 1'b1) $display("[TB] FAIL wrap_full2 got %b exp 1", bus.full);
    else passed++;
    repeat (3) do_read();
    checks++;
    if ({bus.data_out, bus.pkt_busy} !== {8'hD2, 1'b1})
      $display("[TB] FAIL wrap_midpkt got %h/%b exp D2/1", bus.data_out, bus.pkt_busy);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.empty, bus.full, bus.pkt_busy} !== 3'b100)
      $display("[TB] FAIL async_flags got e/f/b=%b%b%b exp 100", bus.empty, bus.full, bus.pkt_busy);
    else passed++;
    checks++;
    if (bus.data_out !== 8'h00) $display("[TB] FAIL async_data got %h exp 00", bus.data_out);
    else passed++;
    tick();
    release_reset();
    checks++;
    if ({bus.empty, bus.data_out} !== {1'b1, 8'h00})
      $display("[TB] FAIL async_after got %b/%h exp 1/00", bus.empty, bus.data_out);
    else passed++;
  endtask

  initial begin
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    test_reset();
    test_packet();
    test_full();
    test_collision();
    test_soft_reset();
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
